// File: rtl/toy_pack.sv
// Shared types and constants for the integer writeback path.
package toy_pack;

    localparam int unsigned REG_WIDTH  = 32;
    localparam int unsigned GPR_NUM    = 32;
    localparam int unsigned WB_SRC_NUM = 6;
    localparam int unsigned WB_CH_NUM  = 4;

    // One buffered result: destination register and its value.
    typedef struct packed {
        logic [4:0]           rd_idx;
        logic [REG_WIDTH-1:0] data;
    } wb_req_t;

    // One-hot GPR write enable for a register index.
    function automatic logic [GPR_NUM-1:0] rd_onehot(input logic [4:0] rd);
        return GPR_NUM'(1) << rd;
    endfunction

endpackage

// File: rtl/toy_wb_arbiter_if.sv
// Result-source channels and GPR write channels of the writeback arbiter.
interface toy_wb_arbiter_if
    import toy_pack::*;
#(
    parameter int unsigned SRC_NUM   = WB_SRC_NUM,
    parameter int unsigned REG_WIDTH = toy_pack::REG_WIDTH
);

    logic [SRC_NUM-1:0]                src_vld;
    logic [SRC_NUM-1:0]                src_rdy;
    logic [SRC_NUM-1:0][4:0]           src_rd_idx;
    logic [SRC_NUM-1:0][REG_WIDTH-1:0] src_data;

    logic [GPR_NUM-1:0]   wr_ch0_en_bitmap;
    logic [GPR_NUM-1:0]   wr_ch1_en_bitmap;
    logic [GPR_NUM-1:0]   wr_ch2_en_bitmap;
    logic [GPR_NUM-1:0]   wr_ch3_en_bitmap;
    logic [REG_WIDTH-1:0] wr_ch0_data;
    logic [REG_WIDTH-1:0] wr_ch1_data;
    logic [REG_WIDTH-1:0] wr_ch2_data;
    logic [REG_WIDTH-1:0] wr_ch3_data;
    logic [GPR_NUM-1:0]   wb_clr_bitmap;

    // Execution units plus register file / scoreboard side.
    modport master (
        output src_vld, src_rd_idx, src_data,
        input  src_rdy,
        input  wr_ch0_en_bitmap, wr_ch1_en_bitmap, wr_ch2_en_bitmap, wr_ch3_en_bitmap,
        input  wr_ch0_data, wr_ch1_data, wr_ch2_data, wr_ch3_data,
        input  wb_clr_bitmap
    );

    // The arbiter itself.
    modport slave (
        input  src_vld, src_rd_idx, src_data,
        output src_rdy,
        output wr_ch0_en_bitmap, wr_ch1_en_bitmap, wr_ch2_en_bitmap, wr_ch3_en_bitmap,
        output wr_ch0_data, wr_ch1_data, wr_ch2_data, wr_ch3_data,
        output wb_clr_bitmap
    );

endinterface

// File: rtl/toy_wb_fifo.sv
// Per-source result FIFO; head is the oldest entry, valid while not empty.
module toy_wb_fifo
    import toy_pack::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wb_req_t head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Payload storage needs no reset; occupancy gates its use.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/toy_wb_arbiter.sv
// Writeback arbiter: buffers results per source and packs up to four of them
// per cycle, round-robin, onto the registered GPR write channels.
module toy_wb_arbiter
    import toy_pack::*;
#(
    parameter int unsigned SRC_NUM    = WB_SRC_NUM,
    parameter int unsigned FIFO_DEPTH = 2,
    // Must match toy_pack::REG_WIDTH since wb_req_t carries the payload.
    parameter int unsigned REG_WIDTH  = toy_pack::REG_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    toy_wb_arbiter_if.slave  bus
);

    localparam int unsigned PTR_W = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;

    wb_req_t              head [SRC_NUM];
    logic [SRC_NUM-1:0]   full;
    logic [SRC_NUM-1:0]   empty;
    logic [SRC_NUM-1:0]   push;
    logic [SRC_NUM-1:0]   pop;

    logic [WB_CH_NUM-1:0] ch_vld;
    logic [4:0]           ch_rd   [WB_CH_NUM];
    logic [REG_WIDTH-1:0] ch_data [WB_CH_NUM];
    logic [GPR_NUM-1:0]   rd_taken;
    logic [2:0]           n_used;
    logic [PTR_W-1:0]     idx;
    logic [PTR_W-1:0]     last_src;
    logic                 any_pop;
    logic                 clr_zero;

    logic [GPR_NUM-1:0]   en_q   [WB_CH_NUM];
    logic [REG_WIDTH-1:0] data_q [WB_CH_NUM];
    logic [GPR_NUM-1:0]   clr_q;
    logic [PTR_W-1:0]     rr_ptr_q;

    for (genvar i = 0; i < SRC_NUM; i++) begin : g_src
        wb_req_t push_req;
        assign push_req = '{rd_idx: bus.src_rd_idx[i], data: bus.src_data[i]};
        assign push[i]  = bus.src_vld[i] & bus.src_rdy[i];

        toy_wb_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[i]),
            .push_data (push_req),
            .pop       (pop[i]),
            .full      (full[i]),
            .empty     (empty[i]),
            .head      (head[i])
        );
    end

    // Ready depends on registered occupancy only; held low during reset.
    assign bus.src_rdy = ~full & {SRC_NUM{rst_n}};

    // Round-robin scan from rr_ptr: rd==0 heads are dropped, others take the
    // next free channel unless their rd was already granted this cycle.
    always_comb begin
        ch_vld   = '0;
        rd_taken = '0;
        n_used   = '0;
        idx      = '0;
        last_src = rr_ptr_q;
        any_pop  = 1'b0;
        clr_zero = 1'b0;
        pop      = '0;
        for (int c = 0; c < WB_CH_NUM; c++) begin
            ch_rd[c]   = '0;
            ch_data[c] = '0;
        end
        for (int k = 0; k < SRC_NUM; k++) begin
            idx = PTR_W'((int'(rr_ptr_q) + k) % SRC_NUM);
            if (!empty[idx]) begin
                if (head[idx].rd_idx == 5'd0) begin
                    pop[idx] = 1'b1;
                    clr_zero = 1'b1;
                    any_pop  = 1'b1;
                    last_src = idx;
                end else if ((n_used < 3'(WB_CH_NUM)) && !rd_taken[head[idx].rd_idx]) begin
                    ch_vld[n_used[1:0]]  = 1'b1;
                    ch_rd[n_used[1:0]]   = head[idx].rd_idx;
                    ch_data[n_used[1:0]] = head[idx].data;
                    rd_taken[head[idx].rd_idx] = 1'b1;
                    n_used   = n_used + 3'd1;
                    pop[idx] = 1'b1;
                    any_pop  = 1'b1;
                    last_src = idx;
                end
            end
        end
    end

    // Register the write channels, the clear bitmap and the scan pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < WB_CH_NUM; c++) begin
                en_q[c]   <= '0;
                data_q[c] <= '0;
            end
            clr_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            for (int c = 0; c < WB_CH_NUM; c++) begin
                en_q[c] <= ch_vld[c] ? rd_onehot(ch_rd[c]) : '0;
                if (ch_vld[c]) data_q[c] <= ch_data[c];
            end
            clr_q <= rd_taken | {{(GPR_NUM-1){1'b0}}, clr_zero};
            if (any_pop) begin
                rr_ptr_q <= (last_src == PTR_W'(SRC_NUM - 1)) ? '0 : last_src + 1'b1;
            end
        end
    end

    assign bus.wr_ch0_en_bitmap = en_q[0];
    assign bus.wr_ch1_en_bitmap = en_q[1];
    assign bus.wr_ch2_en_bitmap = en_q[2];
    assign bus.wr_ch3_en_bitmap = en_q[3];
    assign bus.wr_ch0_data      = data_q[0];
    assign bus.wr_ch1_data      = data_q[1];
    assign bus.wr_ch2_data      = data_q[2];
    assign bus.wr_ch3_data      = data_q[3];
    assign bus.wb_clr_bitmap    = clr_q;

endmodule

// File: tb/tb_toy_wb_arbiter.sv
// Directed bench for toy_wb_arbiter with hand-computed expectations.
module tb_toy_wb_arbiter;
    import toy_pack::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    toy_wb_arbiter_if #(.SRC_NUM(6), .REG_WIDTH(32)) bus ();

    toy_wb_arbiter #(
        .SRC_NUM    (6),
        .FIFO_DEPTH (2),
        .REG_WIDTH  (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, check channel disjointness.
    task automatic tick();
        logic [31:0] b0, b1, b2, b3, ovl;
        @(posedge clk);
        #1;
        b0  = bus.wr_ch0_en_bitmap;
        b1  = bus.wr_ch1_en_bitmap;
        b2  = bus.wr_ch2_en_bitmap;
        b3  = bus.wr_ch3_en_bitmap;
        ovl = (b0 & b1) | (b0 & b2) | (b0 & b3) | (b1 & b2) | (b1 & b3) | (b2 & b3)
            | ((b0 | b1 | b2 | b3) & 32'h1);
        chk("disjoint", ovl, 32'h0);
    endtask

    task automatic set_src(input int i, input logic [4:0] rd, input logic [31:0] data);
        bus.src_vld[i]    = 1'b1;
        bus.src_rd_idx[i] = rd;
        bus.src_data[i]   = data;
    endtask

    task automatic chk_bitmaps(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
        chk({tag, "_ch0"}, bus.wr_ch0_en_bitmap, e0);
        chk({tag, "_ch1"}, bus.wr_ch1_en_bitmap, e1);
        chk({tag, "_ch2"}, bus.wr_ch2_en_bitmap, e2);
        chk({tag, "_ch3"}, bus.wr_ch3_en_bitmap, e3);
    endtask

    task automatic do_reset();
        bus.src_vld = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.src_vld    = '0;
        bus.src_rd_idx = '0;
        bus.src_data   = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rdy", 32'(bus.src_rdy), 32'h0);
        chk_bitmaps("rst", 32'h0, 32'h0, 32'h0, 32'h0);
        chk("rst_clr", bus.wb_clr_bitmap, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_rdy_rel", 32'(bus.src_rdy), 32'h3f);
        chk("rst_rr", 32'(dut.rr_ptr_q), 32'h0);

        // Single write: bitmap visible one edge after the handshake edge
        set_src(0, 5'd5, 32'hDEADBEEF);
        tick();
        bus.src_vld = '0;
        chk("single_e0", bus.wr_ch0_en_bitmap, 32'h0);
        tick();
        chk_bitmaps("single", 32'h20, 32'h0, 32'h0, 32'h0);
        chk("single_data", bus.wr_ch0_data, 32'hDEADBEEF);
        chk("single_clr", bus.wb_clr_bitmap, 32'h20);
        tick();
        chk_bitmaps("single_idle", 32'h0, 32'h0, 32'h0, 32'h0);

        // Six sources at once, rd=1..6
        do_reset();
        for (int i = 0; i < 6; i++) set_src(i, 5'(i + 1), 32'h100 + 32'(i));
        tick();
        bus.src_vld = '0;
        tick();
        chk_bitmaps("six_a", 32'h2, 32'h4, 32'h8, 32'h10);
        chk("six_a_d0", bus.wr_ch0_data, 32'h100);
        chk("six_a_d3", bus.wr_ch3_data, 32'h103);
        chk("six_a_clr", bus.wb_clr_bitmap, 32'h1e);
        tick();
        chk_bitmaps("six_b", 32'h20, 32'h40, 32'h0, 32'h0);
        chk("six_b_d0", bus.wr_ch0_data, 32'h104);
        chk("six_b_d1", bus.wr_ch1_data, 32'h105);
        chk("six_rr", 32'(dut.rr_ptr_q), 32'h0);

        // Same-rd conflict: src3 waits one cycle
        do_reset();
        set_src(1, 5'd7, 32'hA1);
        set_src(3, 5'd7, 32'hA3);
        tick();
        bus.src_vld = '0;
        tick();
        chk_bitmaps("conf_a", 32'h80, 32'h0, 32'h0, 32'h0);
        chk("conf_a_d", bus.wr_ch0_data, 32'hA1);
        tick();
        chk_bitmaps("conf_b", 32'h80, 32'h0, 32'h0, 32'h0);
        chk("conf_b_d", bus.wr_ch0_data, 32'hA3);
        tick();
        chk_bitmaps("conf_idle", 32'h0, 32'h0, 32'h0, 32'h0);

        // rd==0 is dropped but still reported on bit 0
        do_reset();
        set_src(2, 5'd0, 32'h55);
        tick();
        bus.src_vld = '0;
        tick();
        chk_bitmaps("rd0", 32'h0, 32'h0, 32'h0, 32'h0);
        chk("rd0_clr", bus.wb_clr_bitmap, 32'h1);
        chk("rd0_rdy", 32'(bus.src_rdy[2]), 32'h1);
        tick();
        chk("rd0_popped", bus.wb_clr_bitmap, 32'h0);

        // Back-pressure on src5 while sources 0..3 keep the channels busy
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, 5'(i + 1), 32'h10 + 32'(i));
        set_src(5, 5'd10, 32'h5A0);
        tick();
        chk("bp_rdy_1", 32'(bus.src_rdy[5]), 32'h1);
        set_src(5, 5'd11, 32'h5A1);
        tick();
        chk("bp_rdy_full", 32'(bus.src_rdy[5]), 32'h0);
        chk_bitmaps("bp_sat", 32'h2, 32'h4, 32'h8, 32'h10);
        bus.src_vld[5] = 1'b0;
        tick();
        chk("bp_first_bm", bus.wr_ch0_en_bitmap, 32'h400);
        chk("bp_first_d", bus.wr_ch0_data, 32'h5A0);
        chk("bp_rdy_back", 32'(bus.src_rdy[5]), 32'h1);
        tick();
        chk("bp_second_bm", bus.wr_ch1_en_bitmap, 32'h800);
        chk("bp_second_d", bus.wr_ch1_data, 32'h5A1);
        bus.src_vld = '0;
        repeat (3) tick();

        // Reset in the middle of a burst
        do_reset();
        for (int i = 0; i < 6; i++) set_src(i, 5'(i + 10), 32'h200 + 32'(i));
        tick();
        bus.src_vld = '0;
        tick();
        chk_bitmaps("mid_pre", 32'h400, 32'h800, 32'h1000, 32'h2000);
        #2 rst_n = 1'b0;
        #1;
        chk_bitmaps("mid_async", 32'h0, 32'h0, 32'h0, 32'h0);
        chk("mid_async_clr", bus.wb_clr_bitmap, 32'h0);
        chk("mid_async_rdy", 32'(bus.src_rdy), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_bitmaps("mid_post", 32'h0, 32'h0, 32'h0, 32'h0);
        chk("mid_post_rdy", 32'(bus.src_rdy), 32'h3f);
        chk("mid_post_rr", 32'(dut.rr_ptr_q), 32'h0);
        tick();
        chk_bitmaps("mid_stale", 32'h0, 32'h0, 32'h0, 32'h0);
        chk("mid_stale_clr", bus.wb_clr_bitmap, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
